// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared widths and FSM state type for reg_bank_master
//
// Purpose : common definitions imported by the register-bank master files.
// Contents: ADDR_W/DATA_W bus widths, CNT_W transaction counter width,
//           state_t FSM encoding.

package reg_bank_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    WAIT,
    VERIFY,
    RESP
  } state_t;

endpackage

// File: rtl/reg_bank_master_if.sv
// rtl/reg_bank_master_if.sv - command/response/bank signal bundle for reg_bank_master
//
// Purpose : groups the command handshake, response handshake and register
//           bank strobes into one interface.
// Modports: master - the reg_bank_master view (drives cmd_ready, rsp_*, bank_*)
//           slave  - the command source / response sink / bank view
// Signals : cmd_valid, cmd_ready, cmd_wr, cmd_addr[3:0], cmd_data[15:0]
//           rsp_valid, rsp_ready, rsp_data[15:0], rsp_err
//           bank_write_en, bank_read_en, bank_addr[3:0],
//           bank_data_in[15:0], bank_data_out[15:0]

interface reg_bank_master_if;
  import reg_bank_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  logic              bank_write_en;
  logic              bank_read_en;
  logic [ADDR_W-1:0] bank_addr;
  logic [DATA_W-1:0] bank_data_in;
  logic [DATA_W-1:0] bank_data_out;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_data, rsp_ready, bank_data_out,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
           bank_write_en, bank_read_en, bank_addr, bank_data_in
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_data, rsp_ready, bank_data_out,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
           bank_write_en, bank_read_en, bank_addr, bank_data_in
  );

endinterface

// File: rtl/reg_bank_master_rd_lat_timer.sv
// rtl/reg_bank_master_rd_lat_timer.sv - read-latency down-counter (module rd_lat_timer)
//
// Purpose : loaded with READ_LAT on the cycle a bank read strobe is issued;
//           done is high during the last of the READ_LAT following cycles,
//           which is the cycle bank_data_out is valid.
// Ports   : clk, rst (async active-high), load (in), done (out)

module rd_lat_timer #(
  parameter int READ_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  logic [2:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= 3'(READ_LAT);
    end else if (cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  // Count value 1 marks the final wait cycle; it then parks at 0.
  assign done = (cnt == 3'd1);

endmodule

// File: rtl/reg_bank_master.sv
// rtl/reg_bank_master.sv - command-driven register bank master with optional write verify
//
// Purpose : accepts one read/write command at a time, strobes the register
//           bank, waits out the bank read latency and returns a response.
// Params  : READ_LAT (1..4) cycles from bank_read_en to valid bank_data_out
// Ports   : clk, rst (async active-high)
//           bus       - reg_bank_master_if.master (cmd, rsp and bank signals)
//           txn_count - completed response handshakes, wraps 255->0
// Config  : REG_BANK_MASTER_VERIFY_EN - when defined, every write is read
//           back from the bank and rsp_err flags a mismatch; otherwise
//           rsp_err is constant 0 and writes respond straight away.

module reg_bank_master
  import reg_bank_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  reg_bank_master_if.master bus,
  output logic [CNT_W-1:0] txn_count
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] rsp_data_q;
  logic              tmr_load;
  logic              tmr_done;

`ifdef REG_BANK_MASTER_VERIFY_EN
  logic              cap_wr;
  logic              rsp_err_q;
`endif

  rd_lat_timer #(.READ_LAT(READ_LAT)) u_rd_lat_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .done (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state        = state;
    bus.cmd_ready     = 1'b0;
    bus.rsp_valid     = 1'b0;
    bus.bank_write_en = 1'b0;
    bus.bank_read_en  = 1'b0;
    tmr_load          = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          next_state = bus.cmd_wr ? WRITE : READ;
        end
      end
      WRITE: begin
        bus.bank_write_en = 1'b1;
`ifdef REG_BANK_MASTER_VERIFY_EN
        next_state = VERIFY;
`else
        next_state = RESP;
`endif
      end
      READ: begin
        bus.bank_read_en = 1'b1;
        tmr_load         = 1'b1;
        next_state       = WAIT;
      end
`ifdef REG_BANK_MASTER_VERIFY_EN
      // Readback of the address just written; shares WAIT with plain reads.
      VERIFY: begin
        bus.bank_read_en = 1'b1;
        tmr_load         = 1'b1;
        next_state       = WAIT;
      end
`endif
      WAIT: begin
        if (tmr_done) begin
          next_state = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_addr   <= '0;
      cap_data   <= '0;
      rsp_data_q <= '0;
      txn_count  <= '0;
`ifdef REG_BANK_MASTER_VERIFY_EN
      cap_wr     <= 1'b0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      if (state == IDLE && bus.cmd_valid) begin
        cap_addr  <= bus.cmd_addr;
        cap_data  <= bus.cmd_data;
`ifdef REG_BANK_MASTER_VERIFY_EN
        cap_wr    <= bus.cmd_wr;
        rsp_err_q <= 1'b0;
`endif
      end
      // Writes echo their data; with verify this is later replaced by the readback.
      if (state == WRITE) begin
        rsp_data_q <= cap_data;
      end
      if (state == WAIT && tmr_done) begin
        rsp_data_q <= bus.bank_data_out;
`ifdef REG_BANK_MASTER_VERIFY_EN
        rsp_err_q  <= cap_wr && (bus.bank_data_out != cap_data);
`endif
      end
      if (state == RESP && bus.rsp_ready) begin
        txn_count <= txn_count + 8'd1;
      end
    end
  end

  // Bank address/data stay on the captured command until the next accept.
  assign bus.bank_addr    = cap_addr;
  assign bus.bank_data_in = cap_data;
  assign bus.rsp_data     = rsp_data_q;

`ifdef REG_BANK_MASTER_VERIFY_EN
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bank_master.sv
// tb/tb_reg_bank_master.sv - directed self-checking bench for reg_bank_master
//
// Purpose : drives commands through reg_bank_master_if against a register
//           bank model (READ_LAT pipeline, address 5 reads back corrupted)
//           and checks responses, strobes, reset and txn_count wrap.
// Config  : honours REG_BANK_MASTER_VERIFY_EN for write latency and rsp_err.

module tb_reg_bank_master;

  localparam int RL = 1;
  localparam int RD_LAT = RL + 2;
`ifdef REG_BANK_MASTER_VERIFY_EN
  localparam int WR_LAT = RL + 3;
`else
  localparam int WR_LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] txn_count;
  int         n_checks = 0;
  int         n_fail = 0;

  reg_bank_master_if bus ();

  reg_bank_master #(.READ_LAT(RL)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  // Register bank model: writes land on the clock edge, reads return data
  // RL cycles after bank_read_en; address 5 reads back with its low byte flipped.
  logic [15:0] mem [16];
  logic [15:0] rd_pipe [RL];
  always @(posedge clk) begin
    if (bus.bank_write_en) mem[bus.bank_addr] <= bus.bank_data_in;
    if (bus.bank_read_en)
      rd_pipe[0] <= (bus.bank_addr == 4'd5) ? (mem[bus.bank_addr] ^ 16'h00FF) : mem[bus.bank_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.bank_data_out = rd_pipe[RL-1];

  // Call at a negedge with the DUT idle; returns at the negedge after acceptance.
  task automatic issue_cmd(input logic wr, input logic [3:0] a, input logic [15:0] d);
    int guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    bus.cmd_wr    = wr;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // lat = cycles since acceptance when rsp_valid is seen (capped at 30).
  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (bus.rsp_valid !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_checks++; if ({bus.bank_write_en, bus.bank_read_en} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes: got %b expected 00", {bus.bank_write_en, bus.bank_read_en}); end
    n_checks++; if (txn_count !== 8'd0) begin n_fail++; $display("FAIL rst_txn_count: got %0d expected 0", txn_count); end
    n_checks++; if ({bus.rsp_data, bus.rsp_err} !== 17'h0) begin n_fail++; $display("FAIL rst_rsp: got %h/%b expected 0000/0", bus.rsp_data, bus.rsp_err); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b expected 1", bus.cmd_ready); end
    n_checks++; if ({bus.bank_addr, bus.bank_data_in} !== 20'h0) begin n_fail++; $display("FAIL rst_bank_bus: got %h/%h expected 0/0000", bus.bank_addr, bus.bank_data_in); end
  endtask

  task automatic test_write();
    int lat;
    bus.rsp_ready = 1'b1;
    issue_cmd(1'b1, 4'd3, 16'hA5A5);
    n_checks++; if ({bus.bank_write_en, bus.bank_read_en} !== 2'b10) begin n_fail++; $display("FAIL wr_strobes: got %b expected 10", {bus.bank_write_en, bus.bank_read_en}); end
    n_checks++; if ({bus.bank_addr, bus.bank_data_in} !== 20'h3A5A5) begin n_fail++; $display("FAIL wr_bank_bus: got %h/%h expected 3/a5a5", bus.bank_addr, bus.bank_data_in); end
    wait_rsp(1, lat);
    n_checks++; if (lat !== WR_LAT) begin n_fail++; $display("FAIL wr_latency: got %0d expected %0d", lat, WR_LAT); end
    n_checks++; if (bus.rsp_data !== 16'hA5A5) begin n_fail++; $display("FAIL wr_rsp_data: got %h expected a5a5", bus.rsp_data); end
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_err: got %b expected 0", bus.rsp_err); end
    n_checks++; if (bus.bank_write_en !== 1'b0) begin n_fail++; $display("FAIL wr_strobe_once: got %b expected 0", bus.bank_write_en); end
    @(negedge clk);
    n_checks++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL wr_done_idle: got %b expected 01", {bus.rsp_valid, bus.cmd_ready}); end
    n_checks++; if (txn_count !== 8'd1) begin n_fail++; $display("FAIL wr_txn_count: got %0d expected 1", txn_count); end
  endtask

  task automatic test_read();
    int lat;
    issue_cmd(1'b0, 4'd3, 16'h0000);
    n_checks++; if ({bus.bank_write_en, bus.bank_read_en} !== 2'b01) begin n_fail++; $display("FAIL rd_strobes: got %b expected 01", {bus.bank_write_en, bus.bank_read_en}); end
    n_checks++; if (bus.bank_addr !== 4'd3) begin n_fail++; $display("FAIL rd_bank_addr: got %h expected 3", bus.bank_addr); end
    @(negedge clk);
    n_checks++; if ({bus.bank_read_en, bus.rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL rd_strobe_once: got %b expected 00", {bus.bank_read_en, bus.rsp_valid}); end
    wait_rsp(2, lat);
    n_checks++; if (lat !== RD_LAT) begin n_fail++; $display("FAIL rd_latency: got %0d expected %0d", lat, RD_LAT); end
    n_checks++; if ({bus.rsp_data, bus.rsp_err} !== {16'hA5A5, 1'b0}) begin n_fail++; $display("FAIL rd_rsp: got %h/%b expected a5a5/0", bus.rsp_data, bus.rsp_err); end
    @(negedge clk);
    n_checks++; if (txn_count !== 8'd2) begin n_fail++; $display("FAIL rd_txn_count: got %0d expected 2", txn_count); end
  endtask

  task automatic test_backpressure();
    int lat;
    bus.rsp_ready = 1'b0;
    issue_cmd(1'b1, 4'd7, 16'h0F0F);
    wait_rsp(1, lat);
    n_checks++; if (lat !== WR_LAT) begin n_fail++; $display("FAIL bp_latency: got %0d expected %0d", lat, WR_LAT); end
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 4'd9; bus.cmd_data = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_data} !== {2'b10, 16'h0F0F}) begin n_fail++; $display("FAIL bp_hold_%0d: got valid=%b ready=%b data=%h expected 1/0/0f0f", i, bus.rsp_valid, bus.cmd_ready, bus.rsp_data); end
      n_checks++; if ({bus.bank_addr, bus.bank_write_en} !== {4'd7, 1'b0}) begin n_fail++; $display("FAIL bp_no_accept_%0d: got addr=%h we=%b expected 7/0", i, bus.bank_addr, bus.bank_write_en); end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got %b expected 01", {bus.rsp_valid, bus.cmd_ready}); end
    n_checks++; if ({txn_count, bus.bank_addr} !== {8'd3, 4'd7}) begin n_fail++; $display("FAIL bp_txn_addr: got %0d/%h expected 3/7", txn_count, bus.bank_addr); end
  endtask

  task automatic test_reset_mid_wait();
    int lat;
    issue_cmd(1'b0, 4'd3, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if ({bus.rsp_valid, bus.bank_read_en, bus.bank_write_en} !== 3'b000) begin n_fail++; $display("FAIL mid_rst_ctrl: got %b expected 000", {bus.rsp_valid, bus.bank_read_en, bus.bank_write_en}); end
    n_checks++; if ({txn_count, bus.bank_addr, bus.rsp_data} !== 28'h0) begin n_fail++; $display("FAIL mid_rst_data: got txn=%0d addr=%h rsp=%h expected 0", txn_count, bus.bank_addr, bus.rsp_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({bus.rsp_valid, bus.bank_read_en, bus.cmd_ready} !== 3'b001) begin n_fail++; $display("FAIL mid_rst_quiet_%0d: got %b expected 001", i, {bus.rsp_valid, bus.bank_read_en, bus.cmd_ready}); end
    end
    issue_cmd(1'b0, 4'd3, 16'h0000);
    wait_rsp(1, lat);
    n_checks++; if (lat !== RD_LAT) begin n_fail++; $display("FAIL mid_rst_next_lat: got %0d expected %0d", lat, RD_LAT); end
    n_checks++; if (bus.rsp_data !== 16'hA5A5) begin n_fail++; $display("FAIL mid_rst_next_data: got %h expected a5a5", bus.rsp_data); end
    @(negedge clk);
    n_checks++; if (txn_count !== 8'd1) begin n_fail++; $display("FAIL mid_rst_txn: got %0d expected 1", txn_count); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] d;
    for (int i = 0; i < 255; i++) begin
      d = 16'(i * 7 + 1);
      issue_cmd(1'b1, 4'(8 + (i % 4)), d);
      wait_rsp(1, lat);
      n_checks++; if (bus.rsp_data !== d || lat !== WR_LAT) begin n_fail++; $display("FAIL b2b_rsp_%0d: got %h lat %0d expected %h lat %0d", i, bus.rsp_data, lat, d, WR_LAT); end
      if (i == 254) begin
        n_checks++; if (txn_count !== 8'd255) begin n_fail++; $display("FAIL b2b_txn_255: got %0d expected 255", txn_count); end
      end
      @(negedge clk);
    end
    n_checks++; if (txn_count !== 8'd0) begin n_fail++; $display("FAIL b2b_txn_wrap: got %0d expected 0", txn_count); end
  endtask

  task automatic test_verify();
    int lat;
    issue_cmd(1'b1, 4'd5, 16'h1234);
    wait_rsp(1, lat);
    n_checks++; if (lat !== WR_LAT) begin n_fail++; $display("FAIL vf_latency: got %0d expected %0d", lat, WR_LAT); end
`ifdef REG_BANK_MASTER_VERIFY_EN
    n_checks++; if ({bus.rsp_err, bus.rsp_data} !== {1'b1, 16'h12CB}) begin n_fail++; $display("FAIL vf_mismatch: got %b/%h expected 1/12cb", bus.rsp_err, bus.rsp_data); end
    @(negedge clk);
    issue_cmd(1'b1, 4'd6, 16'hBEEF);
    wait_rsp(1, lat);
    n_checks++; if ({bus.rsp_err, bus.rsp_data} !== {1'b0, 16'hBEEF}) begin n_fail++; $display("FAIL vf_match: got %b/%h expected 0/beef", bus.rsp_err, bus.rsp_data); end
`else
    n_checks++; if ({bus.rsp_err, bus.rsp_data} !== {1'b0, 16'h1234}) begin n_fail++; $display("FAIL vf_absent: got %b/%h expected 0/1234", bus.rsp_err, bus.rsp_data); end
`endif
    @(negedge clk);
    issue_cmd(1'b0, 4'd5, 16'h0000);
    wait_rsp(1, lat);
    n_checks++; if ({bus.rsp_err, bus.rsp_data} !== {1'b0, 16'h12CB}) begin n_fail++; $display("FAIL vf_read_no_err: got %b/%h expected 0/12cb", bus.rsp_err, bus.rsp_data); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    test_verify();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no completion expected finish before 1000000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_bank_master.md
REG_BANK_MASTER -- requirements
Module: reg_bank_master

Interface
REQ-001 The block SHALL have parameter READ_LAT, default 1, meaning cycles from bank_read_en assertion to valid bank_data_out (legal 1..4).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port cmd_valid, input, 1, meaning command present.
REQ-005 The block SHALL have port cmd_ready, output, 1, meaning command accepted when high with cmd_valid.
REQ-006 The block SHALL have port cmd_wr, input, 1, meaning 1=write, 0=read.
REQ-007 The block SHALL have port cmd_addr, input, 4, meaning target register.
REQ-008 The block SHALL have port cmd_data, input, 16, meaning write data.
REQ-009 The block SHALL have port rsp_valid, output, 1, meaning response present.
REQ-010 The block SHALL have port rsp_ready, input, 1, meaning response consumed.
REQ-011 The block SHALL have port rsp_data, output, 16, carrying read data, or write data for writes.
REQ-012 The block SHALL have port rsp_err, output, 1, meaning readback mismatch.
REQ-013 The block SHALL have ports bank_write_en, bank_read_en (output, 1 each), bank_addr (output, 4), bank_data_in (output, 16) and bank_data_out (input, 16), driving the register bank.
REQ-014 The block SHALL have port txn_count, output, 8, counting completed transactions.

Function
REQ-015 States SHALL be IDLE, WRITE, READ, WAIT, VERIFY, RESP.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a handshake SHALL capture cmd_wr/cmd_addr/cmd_data and move to WRITE (cmd_wr=1) or READ (cmd_wr=0).
REQ-017 WRITE SHALL assert bank_write_en for exactly one cycle with bank_addr/bank_data_in = captured values, then go to RESP (or VERIFY when enabled).
REQ-018 READ SHALL assert bank_read_en for exactly one cycle with bank_addr = captured address, then go to WAIT.
REQ-019 WAIT SHALL count READ_LAT cycles from read_en assertion, sample bank_data_out into rsp_data on the last cycle, then go to RESP.
REQ-020 bank_write_en and bank_read_en SHALL never be high in the same cycle; bank_addr and bank_data_in SHALL hold captured values until the next accepted command.
REQ-021 RESP SHALL hold rsp_valid=1 and stable rsp_data/rsp_err until rsp_ready=1, then return to IDLE the next cycle; command latency is 2 cycles for write and READ_LAT+2 for read, excluding backpressure.
REQ-022 txn_count SHALL increment by 1 on each rsp_valid&&rsp_ready and wrap 255->0.
REQ-023 cmd_valid asserted outside IDLE SHALL be ignored (no capture, cmd_ready=0).

Reset
REQ-024 rst=1 SHALL immediately force IDLE, cmd_ready=1 after release, and all other outputs, including txn_count, to 0.
REQ-025 Reset mid-operation SHALL abandon the transaction with no response issued and no further bank strobe.

Configuration
REQ-026 With REG_BANK_MASTER_VERIFY_EN defined, each write SHALL be followed by VERIFY: one bank_read_en on the same address, a wait of READ_LAT cycles, then a compare; rsp_err=1 on mismatch, rsp_data=readback value.
REQ-027 Without REG_BANK_MASTER_VERIFY_EN, VERIFY SHALL be absent, writes go WRITE->RESP, and rsp_err SHALL be tied to 0.

Structure
REQ-028 Package reg_bank_pkg SHALL hold ADDR_W=4, DATA_W=16 and the state enum type.
REQ-029 The read-latency down-counter SHALL be sub-module rd_lat_timer (load READ_LAT, done pulse), shared by WAIT and VERIFY.

Verification
REQ-030 Reset released, write addr 3 data 0xA5A5, rsp_ready=1 -> one-cycle bank_write_en with addr 3; rsp_data=0xA5A5, rsp_err=0, txn_count=1.
REQ-031 Read addr 3 after that write, READ_LAT=1 -> one-cycle bank_read_en; rsp_valid after 3 cycles with rsp_data=0xA5A5.
REQ-032 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable and cmd_ready=0 throughout; a new cmd_valid is not accepted.
REQ-033 256 back-to-back transactions -> txn_count wraps to 0.
REQ-034 rst asserted during WAIT -> no rsp_valid, all outputs 0; next command completes normally.
REQ-035 VERIFY_EN defined, bank model corrupts addr 5 -> write 0x1234 to addr 5 returns rsp_err=1 with rsp_data equal to the corrupted value.
